// File: rtl/wire_test.sv
`default_nettype none
// ============================================================================
// wire_test : synchronizes wire a, debounces it onto b, pulses c on each change
// Rev 1.0
// ============================================================================
module wire_test #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  output logic b,
  output logic c
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [SYNC_STAGES-1:0] sync;
  logic                   a_s;
  logic [7:0]             cnt;
  logic [7:0]             cnt_next;
  logic                   c_next;

  // Metastability chain: a enters at bit 0, a_s leaves from the top bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], a};
    end
  end

  assign a_s = sync[SYNC_STAGES-1];
  assign b   = (state == HIGH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOW;
      cnt   <= '0;
      c     <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      c     <= c_next;
    end
  end

  // Any agreement between a_s and b restarts the persistence count.
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    c_next     = 1'b0;
    if (a_s != b) begin
      if (cnt == CNT_LAST) begin
        state_next = (state == LOW) ? HIGH : LOW;
        c_next     = 1'b1;
      end else begin
        cnt_next = cnt + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wire_test.sv
`default_nettype none
// Testbench for wire_test: per-cycle vector table on the default build,
// reset-abort sequences, and a DEBOUNCE=1 build driven by a delay-line model.
`timescale 1ns/1ps
module tb_wire_test;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic a     = 1'b0;
  logic a1    = 1'b0;
  logic b, c, b1, c1;

  always #5 clk = ~clk;

  wire_test #(.SYNC_STAGES(2), .DEBOUNCE(4)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c)
  );

  wire_test #(.SYNC_STAGES(2), .DEBOUNCE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c(c1)
  );

  typedef struct {
    logic rst_n;
    logic a;
    logic b;
    logic c;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic ai, input logic eb, input logic ec, input int n);
    vec_t v;
    v = '{r, ai, eb, ec};
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // Expect b to rise exactly 6 edges from now with a single c pulse on that edge.
  task automatic wait_rise(input string tag);
    int first;
    int pulses;
    first  = 0;
    pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (b === 1'b1 && first == 0) begin
        first = k;
        check({tag, " c at rise"}, c, 1);
      end
      if (c === 1'b1) pulses++;
    end
    check({tag, " latency"}, first, 6);
    check({tag, " pulses"}, pulses, 1);
  endtask

  task automatic reset_abort(input int pre);
    string tag;
    tag = $sformatf("abort%0d", pre);
    @(negedge clk); a = 1'b1;
    repeat (pre) @(posedge clk);
    @(negedge clk); rst_n = 1'b0; #1;
    check({tag, " b at assert"}, b, 0);
    check({tag, " c at assert"}, c, 0);
    repeat (2) begin
      @(posedge clk); #1;
      check({tag, " b in reset"}, b, 0);
    end
    @(negedge clk); rst_n = 1'b1;
    wait_rise({tag, " release1"});
    // Assert mid-cycle with b high: the clear must not wait for a clock edge.
    @(posedge clk); #2; rst_n = 1'b0; #1;
    check({tag, " async b"}, b, 0);
    check({tag, " async c"}, c, 0);
    @(negedge clk); rst_n = 1'b1;
    wait_rise({tag, " release2"});
    @(negedge clk); a = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check({tag, " back low"}, b, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hist[$];
    logic eb, ec;

    // rst_n a  b  c  count
    add(0, 0, 0, 0, 1);   // in reset
    add(1, 0, 0, 0, 4);   // released, idle low
    add(1, 1, 0, 0, 5);   // 0->1 held
    add(1, 1, 1, 1, 1);   //   6th edge: b rises, c pulse
    add(1, 1, 1, 0, 2);
    add(1, 0, 1, 0, 5);   // 1->0 held
    add(1, 0, 0, 1, 1);   //   6th edge: b falls, c pulse
    add(1, 0, 0, 0, 3);
    add(1, 1, 0, 0, 2);   // 2-cycle phases 1,0 rejected
    add(1, 0, 0, 0, 2);
    add(1, 1, 0, 0, 5);   // final 1 held
    add(1, 1, 1, 1, 1);
    add(1, 1, 1, 0, 3);
    add(1, 0, 1, 0, 3);   // 3-cycle glitch while b=1 rejected
    add(1, 1, 1, 0, 5);
    add(1, 0, 1, 0, 5);   // return low
    add(1, 0, 0, 1, 1);
    add(1, 0, 0, 0, 2);

    #1 rst_n = 1'b0;
    #1;
    check("por b", b, 0);
    check("por c", c, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n;
      a     = vecs[i].a;
      @(posedge clk); #1;
      check($sformatf("vec%0d b", i), b, vecs[i].b);
      check($sformatf("vec%0d c", i), c, vecs[i].c);
    end

    reset_abort(2);
    reset_abort(4);

    // DEBOUNCE=1: b equals the a value applied two vectors earlier (3 edges).
    repeat (3) hist.push_back(1'b0);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      a1 = (((k / 3) % 2) == 0) ? 1'b1 : 1'b0;
      hist.push_back(a1);
      @(posedge clk); #1;
      eb = hist[hist.size()-3];
      ec = hist[hist.size()-3] ^ hist[hist.size()-4];
      check($sformatf("db1 k%0d b", k), b1, eb);
      check($sformatf("db1 k%0d c", k), c1, ec);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
